// File: rtl/branch_target_table.sv
// -----------------------------------------------------------------------------
// branch_target_table
//   Writable branch-target table for the fetch path. Each of DEPTH = 2**IDX_W
//   entries holds a valid bit and a TGT_W-bit target. Reads are registered, so
//   the hit/target result appears one cycle after rd_en. A two-state FSM
//   (IDLE/CLEAR) walks the table one entry per cycle to invalidate it in bulk.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   rd_en      in   1      read request, sampled at clk
//   rd_idx     in   IDX_W  read index
//   rd_valid   out  1      one-cycle pulse per accepted read
//   rd_hit     out  1      indexed entry was valid (holds between reads)
//   rd_target  out  TGT_W  target read, DEFAULT_TGT on miss (holds)
//   wr_en      in   1      write request, taken only while wr_ready=1
//   wr_idx     in   IDX_W  write index
//   wr_target  in   TGT_W  target to store
//   wr_ready   out  1      table accepts writes (FSM in IDLE)
//   clr_req    in   1      start bulk clear, ignored while busy
//   busy       out  1      bulk clear in progress
// -----------------------------------------------------------------------------
module branch_target_table #(
    parameter int                 TGT_W       = 8,
    parameter int                 IDX_W       = 2,
    parameter logic [TGT_W-1:0]   DEFAULT_TGT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_hit,
    output logic [TGT_W-1:0] rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TGT_W-1:0] wr_target,
    output logic             wr_ready,
    input  logic             clr_req,
    output logic             busy
);

    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [IDX_W:0]   LAST_CNT = (IDX_W + 1)'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W:0]     clr_cnt_q;
    logic [IDX_W-1:0]   clr_idx;

    logic [DEPTH-1:0]   valid_q;
    logic [TGT_W-1:0]   target_q [DEPTH];

    logic               wr_accept;
    logic               rd_hit_d;
    logic [TGT_W-1:0]   rd_target_d;

    assign wr_ready  = (state_q == IDLE);
    assign busy      = (state_q == CLEAR);
    assign wr_accept = wr_en & wr_ready;
    assign clr_idx   = clr_cnt_q[IDX_W-1:0];

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == LAST_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (clr_req) clr_cnt_q <= '0;
            end else begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage. The clear walk owns the array while busy; writes only land in
    // IDLE, so the two never collide.
    // -------------------------------------------------------------------------
    // NOTE: the table is built from flops, not a RAM macro, so every entry is
    // reset explicitly; a miss after reset depends on valid bits being zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) target_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            valid_q[clr_idx]  <= 1'b0;
            target_q[clr_idx] <= '0;
        end else if (wr_accept) begin
            valid_q[wr_idx]  <= 1'b1;
            target_q[wr_idx] <= wr_target;
        end
    end

    // -------------------------------------------------------------------------
    // Read path. A same-index write in the same cycle is forwarded so the
    // reader sees the new target; during a clear every read misses, even for
    // entries the walk has not reached yet.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_hit_d    = 1'b0;
        rd_target_d = DEFAULT_TGT;
        if (state_q == IDLE) begin
            if (wr_accept && (wr_idx == rd_idx)) begin
                rd_hit_d    = 1'b1;
                rd_target_d = wr_target;
            end else if (valid_q[rd_idx]) begin
                rd_hit_d    = 1'b1;
                rd_target_d = target_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_target <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_hit    <= rd_hit_d;
                rd_target <= rd_target_d;
            end
        end
    end

endmodule
